apb_master_controller: RTL and testbench

- APB-side finite state machine of the AHB-to-APB bridge.
- Consumes the AHB slave interface's qualified request (valid) and its pipelined address, data and write registers.
- Drives a 3-peripheral APB bus through SETUP and ENABLE phases, one transfer at a time.
- Generates hr_readyout back to AHB to stall the master while an APB read or a back-to-back write is in flight.

---
 rtl/apb_master_controller.sv | 204 ++++++++++++++++++++
 tb/tb_apb_master_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_controller.sv
// apb_master_controller
// APB-side sequencer of the AHB-to-APB bridge. Takes the qualified AHB request
// (valid) together with the AHB slave's pipelined address/data/write copies and
// runs one APB transfer at a time through SETUP and ENABLE. hr_readyout stalls
// the AHB master while a read or a back-to-back write is still in flight.
//
// Optional build macro: APB_PREADY_EN
//   defined   : ENABLE states wait for pready=1, with hr_readyout low while held.
//   undefined : pready is ignored and every ENABLE phase lasts exactly one cycle.
//
// Handshake: the AHB side offers a request by raising valid. The request is
// taken on any rising hclk edge where the FSM is in a state that accepts
// requests. hr_readyout=0 tells the master to hold its current address phase
// until hr_readyout returns to 1. On the APB side, penable=1 marks the ENABLE
// cycle of the transfer set up in the cycle before it.
//
// o_dbg_state exposes the FSM state for checkers (ST_IDLE encodes as 0).

module apb_master_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  valid,
    input  logic                  hwrite,
    input  logic                  hwrite_reg,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [ADDR_WIDTH-1:0] haddr_1,
    input  logic [ADDR_WIDTH-1:0] haddr_2,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hwdata_1,
    input  logic                  pready,
    output logic [2:0]            pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  hr_readyout,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

    state_t                r_state;
    logic [2:0]            r_pselx;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_hr_readyout;

    // High while an ENABLE phase must be stretched because the slave is not ready.
    logic w_hold;

`ifdef APB_PREADY_EN
    assign w_hold = !pready;
`else
    logic w_unused_pready;
    assign w_unused_pready = pready;
    assign w_hold          = 1'b0;
`endif

    // Peripheral select from the top six address bits: three 64 MB windows
    // starting at 0x8000_0000; anything else selects no peripheral.
    function automatic logic [2:0] dec_sel(input logic [5:0] top);
        logic [2:0] sel;
        case (top)
            6'b100000: sel = 3'b001;
            6'b100001: sel = 3'b010;
            6'b100010: sel = 3'b100;
            default:   sel = 3'b000;
        endcase
        return sel;
    endfunction

    // Transfer sequencer: next state and all APB/AHB outputs, loaded on the
    // edge that enters each state.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state       <= ST_IDLE;
            r_pselx       <= 3'b000;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_hr_readyout <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                    if (r_state != ST_IDLE && w_hold) begin
                        r_hr_readyout <= 1'b0;
                    end else if (valid && !hwrite) begin
                        r_state       <= ST_READ;
                        r_paddr       <= haddr;
                        r_pselx       <= dec_sel(haddr[ADDR_WIDTH-1 -: 6]);
                        r_pwrite      <= 1'b0;
                        r_penable     <= 1'b0;
                        r_hr_readyout <= 1'b0;
                    end else if (valid) begin
                        // Write data arrives one cycle later; wait for it.
                        r_state       <= ST_WWAIT;
                        r_pselx       <= 3'b000;
                        r_penable     <= 1'b0;
                        r_hr_readyout <= 1'b1;
                    end else begin
                        r_state       <= ST_IDLE;
                        r_pselx       <= 3'b000;
                        r_penable     <= 1'b0;
                        r_hr_readyout <= 1'b1;
                    end
                end

                ST_READ: begin
                    r_state       <= ST_RENABLE;
                    r_penable     <= 1'b1;
                    r_hr_readyout <= 1'b1;
                end

                ST_WWAIT: begin
                    r_paddr   <= haddr_1;
                    r_pwdata  <= hwdata;
                    r_pselx   <= dec_sel(haddr_1[ADDR_WIDTH-1 -: 6]);
                    r_pwrite  <= 1'b1;
                    r_penable <= 1'b0;
                    if (valid) begin
                        // Another request is already queued behind this write.
                        r_state       <= ST_WRITEP;
                        r_hr_readyout <= 1'b0;
                    end else begin
                        r_state       <= ST_WRITE;
                        r_hr_readyout <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    r_state       <= valid ? ST_WENABLEP : ST_WENABLE;
                    r_penable     <= 1'b1;
                    r_hr_readyout <= 1'b1;
                end

                ST_WRITEP: begin
                    r_state       <= ST_WENABLEP;
                    r_penable     <= 1'b1;
                    r_hr_readyout <= 1'b1;
                end

                ST_WENABLEP: begin
                    if (w_hold) begin
                        r_hr_readyout <= 1'b0;
                    end else if (!hwrite_reg) begin
                        // Queued request is a read; its address is one stage old.
                        r_state       <= ST_READ;
                        r_paddr       <= haddr_1;
                        r_pselx       <= dec_sel(haddr_1[ADDR_WIDTH-1 -: 6]);
                        r_pwrite      <= 1'b0;
                        r_penable     <= 1'b0;
                        r_hr_readyout <= 1'b0;
                    end else begin
                        // Queued request is a write; address two stages old,
                        // data one stage old.
                        r_paddr   <= haddr_2;
                        r_pwdata  <= hwdata_1;
                        r_pselx   <= dec_sel(haddr_2[ADDR_WIDTH-1 -: 6]);
                        r_pwrite  <= 1'b1;
                        r_penable <= 1'b0;
                        if (valid) begin
                            r_state       <= ST_WRITEP;
                            r_hr_readyout <= 1'b0;
                        end else begin
                            r_state       <= ST_WRITE;
                            r_hr_readyout <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_pselx       <= 3'b000;
                    r_penable     <= 1'b0;
                    r_hr_readyout <= 1'b1;
                end
            endcase
        end
    end

    assign pselx       = r_pselx;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign hr_readyout = r_hr_readyout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master_controller.sv
// Bench for apb_master_controller: directed scenarios followed by randomized
// AHB-side traffic, compared cycle by cycle against a phase-level reference
// model and a transfer scoreboard.

module tb_apb_master_controller;

    // ---------------- clock / reset ----------------
    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        hreset = 1'b1;
    logic        valid = 1'b0, hwrite = 1'b0, hwrite_reg = 1'b0, pready = 1'b1;
    logic [31:0] haddr = '0, haddr_1 = '0, haddr_2 = '0;
    logic [31:0] hwdata = '0, hwdata_1 = '0;
    logic [2:0]  pselx;
    logic        penable, pwrite, hr_readyout;
    logic [31:0] paddr, pwdata;
    logic [2:0]  dbg_state;

    apb_master_controller dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .valid       (valid),
        .hwrite      (hwrite),
        .hwrite_reg  (hwrite_reg),
        .haddr       (haddr),
        .haddr_1     (haddr_1),
        .haddr_2     (haddr_2),
        .hwdata      (hwdata),
        .hwdata_1    (hwdata_1),
        .pready      (pready),
        .pselx       (pselx),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .hr_readyout (hr_readyout),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [67:0] exp_q[$];   // {pwrite, pselx, paddr, write data or 0}
    logic        prev_en = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    // Tracks the APB phase (idle, waiting for write data, setup, access) plus
    // whether a second request is already queued, rather than bridge states.
    localparam int PH_IDLE = 0, PH_DWAIT = 1, PH_SETUP = 2, PH_ACCESS = 3;
    int          m_phase = PH_IDLE;
    logic        m_wr = 1'b0, m_pipe = 1'b0;
    logic [2:0]  m_sel = '0;
    logic        m_en = 1'b0, m_pw = 1'b0, m_rdy = 1'b1;
    logic [31:0] m_addr = '0, m_data = '0;

    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
        if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
        if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
        return 3'b000;
    endfunction

    function automatic void m_go_idle_like(input int ph);
        m_phase = ph; m_sel = 3'b000; m_en = 1'b0; m_rdy = 1'b1;
    endfunction

    function automatic void m_setup_read(input logic [31:0] a);
        m_phase = PH_SETUP; m_wr = 1'b0; m_pipe = 1'b0;
        m_addr = a; m_sel = ref_sel(a); m_pw = 1'b0; m_en = 1'b0; m_rdy = 1'b0;
    endfunction

    function automatic void m_setup_write(input logic [31:0] a, input logic [31:0] d, input logic queued);
        m_phase = PH_SETUP; m_wr = 1'b1; m_pipe = queued;
        m_addr = a; m_data = d; m_sel = ref_sel(a); m_pw = 1'b1; m_en = 1'b0; m_rdy = !queued;
    endfunction

    function automatic void m_accept();
        if (valid && !hwrite) m_setup_read(haddr);
        else if (valid)       m_go_idle_like(PH_DWAIT);
        else                  m_go_idle_like(PH_IDLE);
    endfunction

    function automatic void model_step();
        logic stall;
        stall = 1'b0;
`ifdef APB_PREADY_EN
        stall = (m_phase == PH_ACCESS) && !pready;
`endif
        if (hreset) begin
            m_phase = PH_IDLE; m_wr = 1'b0; m_pipe = 1'b0;
            m_sel = '0; m_en = 1'b0; m_pw = 1'b0; m_rdy = 1'b1; m_addr = '0; m_data = '0;
            exp_q.delete();
        end else if (stall) begin
            m_rdy = 1'b0;
        end else begin
            case (m_phase)
                PH_IDLE:  m_accept();
                PH_DWAIT: m_setup_write(haddr_1, hwdata, valid);
                PH_SETUP: begin
                    m_pipe  = m_wr && (m_pipe || valid);
                    m_phase = PH_ACCESS; m_en = 1'b1; m_rdy = 1'b1;
                    exp_q.push_back({m_pw, m_sel, m_addr, m_pw ? m_data : 32'h0});
                end
                default: begin
                    if (!m_pipe)          m_accept();
                    else if (!hwrite_reg) m_setup_read(haddr_1);
                    else                  m_setup_write(haddr_2, hwdata_1, valid);
                end
            endcase
        end
    endfunction

    task automatic compare_all();
        check("pselx", pselx, m_sel);
        check("penable", penable, m_en);
        check("pwrite", pwrite, m_pw);
        check("paddr", paddr, m_addr);
        check("pwdata", pwdata, m_data);
        check("hr_readyout", hr_readyout, m_rdy);
        if (penable && !prev_en) begin
            if (exp_q.size() == 0) check("xfer_unexpected", 1, 0);
            else check("xfer", {pwrite, pselx, paddr, pwrite ? pwdata : 32'h0}, exp_q.pop_front());
        end
        prev_en = penable;
    endtask

    // ---------------- driver ----------------
    // One bus cycle: shift the AHB-side pipeline copies, apply new inputs on the
    // falling edge, advance the model on the rising edge, compare 1 ns later.
    task automatic step(input logic rst, input logic v, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic pr);
        @(negedge hclk);
        hwrite_reg = hwrite;
        haddr_2    = haddr_1;
        haddr_1    = haddr;
        hwdata_1   = hwdata;
        hreset = rst; valid = v; hwrite = w; haddr = a; hwdata = d; pready = pr;
        @(posedge hclk);
        model_step();
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] off;
        case ($urandom_range(0, 3))
            0:       off = 32'h03FF_FFFF;
            1:       off = 32'h0;
            default: off = $urandom & 32'h03FF_FFFF;
        endcase
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000 + off;
            1:       return 32'h8400_0000 + off;
            2:       return 32'h8800_0000 + off;
            3:       return 32'h8C00_0000 + off;
            4:       return 32'h7FFF_FFFF - off;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        // Reset held for two cycles.
        step(1, 0, 0, 32'h0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 32'h0, 1);
        check("rst_pselx", pselx, 3'b000);
        check("rst_penable", penable, 1'b0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_hready", hr_readyout, 1'b1);
        check("rst_state", dbg_state, 3'd0);

        // Single read.
        step(0, 1, 0, 32'h8000_0010, 32'h0, 1);
        check("rd_setup_paddr", paddr, 32'h8000_0010);
        check("rd_setup_sel", pselx, 3'b001);
        check("rd_setup_hready", hr_readyout, 1'b0);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("rd_enable", {penable, hr_readyout}, 2'b11);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("rd_idle", {pselx, penable, hr_readyout}, 5'b00001);

        // Single write: address phase, then data phase.
        step(0, 1, 1, 32'h8400_0004, 32'h0, 1);
        check("wr_wait_sel", pselx, 3'b000);
        step(0, 0, 0, 32'h0, 32'hDEAD_BEEF, 1);
        check("wr_setup", {pwrite, pselx, paddr, pwdata}, {1'b1, 3'b010, 32'h8400_0004, 32'hDEAD_BEEF});
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("wr_enable", penable, 1'b1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Back-to-back writes; master holds its address phase while stalled.
        step(0, 1, 1, 32'h8800_0000, 32'h0, 1);
        step(0, 1, 1, 32'h8800_0004, 32'h11, 1);
        check("b2b_first", {paddr, pwdata, hr_readyout}, {32'h8800_0000, 32'h11, 1'b0});
        step(0, 0, 1, 32'h8800_0004, 32'h22, 1);
        check("b2b_enable", penable, 1'b1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("b2b_second", {pselx, paddr, pwdata, hr_readyout}, {3'b100, 32'h8800_0004, 32'h22, 1'b1});
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Write followed by a read.
        step(0, 1, 1, 32'h8400_0100, 32'h0, 1);
        step(0, 1, 0, 32'h8000_0020, 32'h33, 1);
        step(0, 0, 0, 32'h8000_0020, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("w2r_read", {pwrite, pselx, paddr}, {1'b0, 3'b001, 32'h8000_0020});
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);

        // Reset during a read ENABLE phase.
        step(0, 1, 0, 32'h8800_0040, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("mid_enable", penable, 1'b1);
        step(1, 0, 0, 32'h0, 32'h0, 1);
        check("mid_rst", {pselx, penable, hr_readyout}, 5'b00001);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 rand_addr(), $urandom, $urandom_range(0, 3) != 0);
        end
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 1);
        check("xfer_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
